// File: rtl/half_duplex_pad_pkg.sv
// Shared types and constants for the half-duplex pad arbiter and its bit timer.
package half_duplex_pad_pkg;

  localparam int BIT_CNT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_TURN,
    S_RX,
    S_DONE
  } state_t;

endpackage

// File: rtl/bit_timer.sv
// Free-running bit-period down-counter: tick_o flags the last clock of each
// period, mid_o flags clock CLKDIV/2 of the period.
module bit_timer #(
  parameter int CLKDIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic       tick_o,
  output logic       mid_o
);

  localparam logic [7:0] MID_VAL = 8'(CLKDIV - 1 - CLKDIV / 2);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Counting down from CLKDIV-1 puts clock 0 of a period at the load value.
  always_comb begin
    cnt_d = cnt_q - 8'd1;
    if (load_i || (cnt_q == 8'd0)) begin
      cnt_d = load_val_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == 8'd0);
  assign mid_o  = (cnt_q == MID_VAL);

endmodule

// File: rtl/half_duplex_pad_arb.sv
// Two requesters share one bidirectional pad: each transaction sends a byte
// LSB first, turns the bus around, then receives a byte back.
module half_duplex_pad_arb
  import half_duplex_pad_pkg::*;
#(
  parameter int CLKDIV = 4,
  parameter int TURN   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  input  logic [7:0] tx_data_a,
  input  logic [7:0] tx_data_b,
  output logic [1:0] req_ready,
  output logic [7:0] rx_data,
  output logic [1:0] rx_done,
  output logic       pad_i,
  output logic       pad_t,
  input  logic       pad_o,
  output logic       busy
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = '1;
  localparam logic [3:0]           TURN_LAST = 4'(TURN - 1);
  localparam logic [7:0]           RELOAD    = 8'(CLKDIV - 1);

  state_t               state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [3:0]           turn_cnt_q, turn_cnt_d;
  logic [7:0]           tx_q, tx_d;
  logic [7:0]           rx_shift_q, rx_shift_d;
  logic [7:0]           rx_data_q;
  logic [1:0]           rx_done_q;
  logic                 owner_q, owner_d;
  logic                 last_q, last_d;
  logic                 pad_i_q, pad_i_d;
  logic                 pad_t_q;
  logic                 busy_q;
  logic [1:0]           grant_c;
  logic                 grant_b;
  logic                 load;
  logic                 tick;
  logic                 mid;

  bit_timer #(.CLKDIV(CLKDIV)) u_bit_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .load_val_i (RELOAD),
    .tick_o     (tick),
    .mid_o      (mid)
  );

  // With both requesting, whoever was not served last wins.
  assign grant_b = (req_valid == 2'b11) ? ~last_q : req_valid[1];

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    turn_cnt_d = turn_cnt_q;
    tx_d       = tx_q;
    rx_shift_d = rx_shift_q;
    owner_d    = owner_q;
    last_d     = last_q;
    load       = 1'b0;
    grant_c    = 2'b00;
    unique case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          grant_c   = grant_b ? 2'b10 : 2'b01;
          owner_d   = grant_b;
          last_d    = grant_b;
          tx_d      = grant_b ? tx_data_b : tx_data_a;
          bit_cnt_d = '0;
          load      = 1'b1;
          state_d   = S_TX;
        end
      end
      S_TX: begin
        if (tick) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            turn_cnt_d = 4'd0;
            state_d    = S_TURN;
          end
        end
      end
      S_TURN: begin
        if (tick) begin
          if (turn_cnt_q == TURN_LAST) begin
            bit_cnt_d = '0;
            state_d   = S_RX;
          end else begin
            turn_cnt_d = turn_cnt_q + 4'd1;
          end
        end
      end
      S_RX: begin
        if (mid) begin
          rx_shift_d = {pad_o, rx_shift_q[7:1]};
        end
        if (tick) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Pad registers follow the next state so they line up with the state itself.
    pad_i_d = (state_d == S_TX) ? tx_d[bit_cnt_d] : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      turn_cnt_q <= 4'd0;
      tx_q       <= 8'h00;
      rx_shift_q <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_done_q  <= 2'b00;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      pad_i_q    <= 1'b0;
      pad_t_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      turn_cnt_q <= turn_cnt_d;
      tx_q       <= tx_d;
      rx_shift_q <= rx_shift_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      pad_i_q    <= pad_i_d;
      pad_t_q    <= (state_d != S_TX);
      busy_q     <= (state_d != S_IDLE);
      rx_done_q  <= (state_q == S_DONE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
      if (state_q == S_DONE) begin
        rx_data_q <= rx_shift_q;
      end
    end
  end

  // The grant pulse is combinational in IDLE, so it is masked while reset is held.
  assign req_ready = rst ? 2'b00 : grant_c;
  assign rx_data   = rx_data_q;
  assign rx_done   = rx_done_q;
  assign pad_i     = pad_i_q;
  assign pad_t     = pad_t_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_half_duplex_pad_arb.sv
// Directed bench for half_duplex_pad_arb: default instance (CLKDIV=4, TURN=2)
// plus a fast instance (CLKDIV=2, TURN=1).
module tb_half_duplex_pad_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] reqValid [2];
  logic [7:0] txA      [2];
  logic [7:0] txB      [2];
  logic       padO     [2];
  logic [1:0] reqReady [2];
  logic [7:0] rxData   [2];
  logic [1:0] rxDone   [2];
  logic       padI     [2];
  logic       padT     [2];
  logic       busy     [2];
  logic [7:0] lastRx   [2];
  int         assertCount = 0;
  int         failCount   = 0;

  always #5 clk = ~clk;

  half_duplex_pad_arb dut0 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (reqValid[0]),
    .tx_data_a (txA[0]),
    .tx_data_b (txB[0]),
    .req_ready (reqReady[0]),
    .rx_data   (rxData[0]),
    .rx_done   (rxDone[0]),
    .pad_i     (padI[0]),
    .pad_t     (padT[0]),
    .pad_o     (padO[0]),
    .busy      (busy[0])
  );

  half_duplex_pad_arb #(.CLKDIV(2), .TURN(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (reqValid[1]),
    .tx_data_a (txA[1]),
    .tx_data_b (txB[1]),
    .req_ready (reqReady[1]),
    .rx_data   (rxData[1]),
    .rx_done   (rxDone[1]),
    .pad_i     (padI[1]),
    .pad_t     (padT[1]),
    .pad_o     (padO[1]),
    .busy      (busy[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Whenever the pad is driven the block must be busy, and completion stays one-hot.
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      checkOutput("inv_padt_busy", 32'(padT[s] | busy[s]), 32'd1);
      checkOutput("inv_done_onehot", 32'(rxDone[s] == 2'b11), 32'd0);
    end
  end

  task automatic idleCycle();
    @(posedge clk);
    #1;
  endtask

  // One full transaction, entered one time unit after a rising edge while IDLE.
  task automatic applyStimulus(input int s, input logic [1:0] req, input logic [7:0] a,
                               input logic [7:0] b, input logic [7:0] rxByte, input int owner,
                               input bit holdReq, input logic [1:0] doneNow);
    int         cd;
    int         tn;
    int         rxStart;
    int         bIdx;
    int         j;
    logic [1:0] oh;
    logic [7:0] txExp;
    logic [6:0] expv;
    cd      = (s == 1) ? 2 : 4;
    tn      = (s == 1) ? 1 : 2;
    rxStart = (8 + tn) * cd;
    oh      = (owner == 1) ? 2'b10 : 2'b01;
    txExp   = (owner == 1) ? b : a;
    reqValid[s] = req;
    txA[s]      = a;
    txB[s]      = b;
    padO[s]     = 1'b0;
    #1;
    checkOutput("grant", 32'({reqReady[s], rxDone[s], busy[s], padT[s], padI[s], rxData[s]}),
                32'({oh, doneNow, 1'b0, 1'b1, 1'b0, lastRx[s]}));
    @(posedge clk);
    #1;
    txA[s] = ~a;
    txB[s] = ~b;
    if (!holdReq) reqValid[s] = 2'b00;
    for (int k = 0; k < (16 + tn) * cd; k++) begin
      if (k >= rxStart) begin
        bIdx    = (k - rxStart) / cd;
        j       = (k - rxStart) % cd;
        padO[s] = (j == cd / 2) ? rxByte[bIdx] : ~rxByte[bIdx];
        expv    = 7'b0000110;
      end else if (k >= 8 * cd) begin
        expv = 7'b0000110;
      end else begin
        expv = {4'b0000, 1'b1, 1'b0, txExp[k / cd]};
      end
      #1;
      checkOutput("xfer", 32'({reqReady[s], rxDone[s], busy[s], padT[s], padI[s]}), 32'(expv));
      @(posedge clk);
      #1;
    end
    padO[s] = 1'b0;
    #1;
    checkOutput("done_state", 32'({rxDone[s], busy[s], padT[s], padI[s]}), 32'({2'b00, 3'b110}));
    @(posedge clk);
    #1;
    checkOutput("rx_done", 32'({rxDone[s], busy[s], padT[s], padI[s], rxData[s]}),
                32'({oh, 3'b010, rxByte}));
    lastRx[s] = rxByte;
  endtask

  initial begin
    bit sawDone;
    for (int s = 0; s < 2; s++) begin
      reqValid[s] = 2'b00;
      txA[s]      = 8'h00;
      txB[s]      = 8'h00;
      padO[s]     = 1'b0;
      lastRx[s]   = 8'h00;
    end

    // Reset: requests held high must not produce a grant while reset is asserted.
    #2 rst = 1'b1;
    reqValid[0] = 2'b11;
    reqValid[1] = 2'b11;
    #1;
    for (int s = 0; s < 2; s++) begin
      checkOutput("reset", 32'({reqReady[s], rxDone[s], busy[s], padT[s], padI[s], rxData[s]}),
                  32'({2'b00, 2'b00, 3'b010, 8'h00}));
    end
    repeat (2) @(posedge clk);
    #1;
    reqValid[0] = 2'b00;
    reqValid[1] = 2'b00;
    rst = 1'b0;
    idleCycle();

    // A alone, then a byte whose input changes right after the grant, then B alone.
    applyStimulus(0, 2'b01, 8'hA5, 8'h11, 8'h3C, 0, 1'b0, 2'b00);
    idleCycle();
    applyStimulus(0, 2'b01, 8'h0F, 8'h22, 8'h81, 0, 1'b0, 2'b00);
    idleCycle();
    applyStimulus(0, 2'b10, 8'h44, 8'h5A, 8'hC3, 1, 1'b0, 2'b00);
    idleCycle();

    // Both held through a transaction: the other requester is granted at once in IDLE.
    applyStimulus(0, 2'b11, 8'h33, 8'hCC, 8'h18, 0, 1'b1, 2'b00);
    applyStimulus(0, 2'b11, 8'h44, 8'h66, 8'h7E, 1, 1'b0, 2'b01);
    idleCycle();

    // Reset during RX bit 3 aborts without a completion pulse.
    reqValid[0] = 2'b01;
    txA[0]      = 8'h77;
    padO[0]     = 1'b1;
    #1;
    checkOutput("abort_grant", 32'(reqReady[0]), 32'(2'b01));
    idleCycle();
    reqValid[0] = 2'b00;
    repeat (53) @(posedge clk);
    #1;
    checkOutput("abort_in_rx", 32'({busy[0], padT[0], rxDone[0]}), 32'({2'b11, 2'b00}));
    rst = 1'b1;
    #1;
    checkOutput("abort_reset", 32'({reqReady[0], rxDone[0], busy[0], padT[0], padI[0], rxData[0]}),
                32'({2'b00, 2'b00, 3'b010, 8'h00}));
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b0;
    padO[0] = 1'b0;
    sawDone = 1'b0;
    for (int i = 0; i < 80; i++) begin
      idleCycle();
      sawDone = sawDone | (|rxDone[0]);
    end
    checkOutput("abort_no_done", 32'(sawDone), 32'd0);
    lastRx[0] = 8'h00;

    // After reset A has priority again, then strict alternation.
    applyStimulus(0, 2'b11, 8'h12, 8'h34, 8'h56, 0, 1'b0, 2'b00);
    idleCycle();
    applyStimulus(0, 2'b11, 8'h9A, 8'hBC, 8'hDE, 1, 1'b0, 2'b00);
    idleCycle();
    applyStimulus(0, 2'b11, 8'hF1, 8'h2E, 8'h01, 0, 1'b0, 2'b00);
    idleCycle();
    applyStimulus(0, 2'b11, 8'h80, 8'h7F, 8'hFE, 1, 1'b0, 2'b00);
    idleCycle();

    // Fast instance: mid-bit sample lands on clock 1, 36-cycle latency.
    applyStimulus(1, 2'b11, 8'h96, 8'h69, 8'h5B, 0, 1'b0, 2'b00);
    idleCycle();
    applyStimulus(1, 2'b11, 8'h0F, 8'hE1, 8'hA4, 1, 1'b0, 2'b00);
    idleCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
